// File: rtl/scm_pkg.sv
// Shared types and helpers for the latch-based multi-read/multi-write register file.
package scm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int num_byte(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// Glitch-free clock gate: the enable is latched while the clock is low.
module cluster_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_q;

    always_latch begin
        if (!clk_i) en_q <= en_i | test_en_i;
    end

    assign clk_o = clk_i & en_q;

endmodule

// File: rtl/register_file_mrmw_clr.sv
// Latch-based register file with NUM_RPORTS read ports, NUM_WPORTS byte-enabled write
// ports and a self-timed zero-clear sequence that runs after reset or on ClearReq.
module register_file_mrmw_clr
    import scm_pkg::*;
#(
    parameter  int ADDR_WIDTH = 5,
    parameter  int NUM_WORDS  = 2**ADDR_WIDTH,
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_RPORTS = 2,
    parameter  int NUM_WPORTS = 2,
    localparam int NUM_BYTE   = num_byte(DATA_WIDTH)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    ClearReq,
    output logic                                    Busy,
    input  logic [NUM_RPORTS-1:0]                   ReadEnable,
    input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]   ReadAddr,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]   ReadData,
    input  logic [NUM_WPORTS-1:0]                   WriteEnable,
    input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]   WriteAddr,
    input  logic [NUM_WPORTS-1:0][NUM_BYTE-1:0][7:0] WriteData,
    input  logic [NUM_WPORTS-1:0][NUM_BYTE-1:0]     WriteBE
);

    clr_state_e                                 state_q;
    logic [ADDR_WIDTH-1:0]                      CntxDP;

    logic [NUM_WPORTS-1:0]                      we_q;
    logic                                       clr_q;
    logic [ADDR_WIDTH-1:0]                      clr_addr_q;
    logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]      waddr_q;
    logic [NUM_WPORTS-1:0][NUM_BYTE-1:0][7:0]   wdata_q;
    logic [NUM_WPORTS-1:0][NUM_BYTE-1:0]        wbe_q;
    logic                                       wr_gate_en_d;
    logic                                       clk_wr;

    logic [NUM_RPORTS-1:0]                      rvalid_q;
    logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]      raddr_q;
    logic [NUM_BYTE-1:0][7:0]                   mem_rd [NUM_WORDS];

    // Clear sequencer: reset lands in CLEAR so storage is zeroed before first use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            CntxDP  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ClearReq) begin
                        state_q <= CLEAR;
                        CntxDP  <= '0;
                    end
                end
                CLEAR: begin
                    CntxDP <= CntxDP + 1'b1;
                    if (CntxDP == ADDR_WIDTH'(NUM_WORDS - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = (state_q == CLEAR);

    // Per-edge record of who owns the storage latches during the following high phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= '0;
            clr_q      <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            we_q       <= Busy ? '0 : WriteEnable;
            clr_q      <= Busy;
            clr_addr_q <= CntxDP;
        end
    end

    assign wr_gate_en_d = (|WriteEnable) & ~Busy;

    cluster_clock_gating u_wr_gate (
        .clk_i     (clk),
        .en_i      (wr_gate_en_d),
        .test_en_i (1'b0),
        .clk_o     (clk_wr)
    );

    always_ff @(posedge clk_wr) begin
        waddr_q <= WriteAddr;
        wdata_q <= WriteData;
        wbe_q   <= WriteBE;
    end

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        for (genvar gj = 0; gj < NUM_BYTE; gj++) begin : g_byte
            logic       en_d;
            logic       gclk;
            logic [7:0] wbyte;
            logic [7:0] byte_q;

            always_comb begin
                en_d = Busy && (CntxDP == ADDR_WIDTH'(gi));
                for (int p = 0; p < NUM_WPORTS; p++) begin
                    if (!Busy && WriteEnable[p] && WriteAddr[p] == ADDR_WIDTH'(gi)
                        && WriteBE[p][gj]) en_d = 1'b1;
                end
            end

            cluster_clock_gating u_cg (
                .clk_i     (clk),
                .en_i      (en_d),
                .test_en_i (1'b0),
                .clk_o     (gclk)
            );

            // Descending scan so the lowest-indexed port wins; the clear overrides all.
            always_comb begin
                wbyte = '0;
                for (int p = NUM_WPORTS - 1; p >= 0; p--) begin
                    if (we_q[p] && waddr_q[p] == ADDR_WIDTH'(gi) && wbe_q[p][gj])
                        wbyte = wdata_q[p][gj];
                end
                if (clr_q && clr_addr_q == ADDR_WIDTH'(gi)) wbyte = '0;
            end

            always_latch begin
                if (gclk) byte_q <= wbyte;
            end

            assign mem_rd[gi][gj] = byte_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            raddr_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_RPORTS; r++) begin
                if (ReadEnable[r]) begin
                    raddr_q[r]  <= ReadAddr[r];
                    rvalid_q[r] <= 1'b1;
                end
            end
        end
    end

    // Addresses beyond NUM_WORDS never match and therefore read as zero.
    always_comb begin
        ReadData = '0;
        for (int r = 0; r < NUM_RPORTS; r++) begin
            if (rvalid_q[r]) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    if (raddr_q[r] == ADDR_WIDTH'(w)) ReadData[r] = mem_rd[w];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_mrmw_clr.sv
// Directed self-checking bench: a 32-word instance for the main scenarios and a
// 20-word instance for out-of-range addressing.
module tb_register_file_mrmw_clr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  clr_req, busy;
    logic [1:0]            ren, wen;
    logic [1:0][4:0]       raddr, waddr;
    logic [1:0][31:0]      rdata;
    logic [1:0][3:0][7:0]  wdata;
    logic [1:0][3:0]       wbe;

    logic                  c_clr_req, c_busy;
    logic [1:0]            c_ren, c_wen;
    logic [1:0][4:0]       c_raddr, c_waddr;
    logic [1:0][31:0]      c_rdata;
    logic [1:0][3:0][7:0]  c_wdata;
    logic [1:0][3:0]       c_wbe;

    int checks = 0;
    int errors = 0;

    register_file_mrmw_clr #(.ADDR_WIDTH(5), .NUM_WORDS(32), .DATA_WIDTH(32),
                             .NUM_RPORTS(2), .NUM_WPORTS(2)) dut (
        .clk(clk), .rst(rst), .ClearReq(clr_req), .Busy(busy),
        .ReadEnable(ren), .ReadAddr(raddr), .ReadData(rdata),
        .WriteEnable(wen), .WriteAddr(waddr), .WriteData(wdata), .WriteBE(wbe)
    );

    register_file_mrmw_clr #(.ADDR_WIDTH(5), .NUM_WORDS(20), .DATA_WIDTH(32),
                             .NUM_RPORTS(2), .NUM_WPORTS(2)) dut20 (
        .clk(clk), .rst(rst), .ClearReq(c_clr_req), .Busy(c_busy),
        .ReadEnable(c_ren), .ReadAddr(c_raddr), .ReadData(c_rdata),
        .WriteEnable(c_wen), .WriteAddr(c_waddr), .WriteData(c_wdata), .WriteBE(c_wbe)
    );

    task automatic drive_wr(input int p, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        wen[p] = 1'b1; waddr[p] = a; wdata[p] = d; wbe[p] = be;
        $display("wr  port=%0d addr=%0d data=%h be=%b", p, a, d, be);
    endtask

    task automatic drive_rd(input int p, input logic [4:0] a);
        ren[p] = 1'b1; raddr[p] = a;
        $display("rd  port=%0d addr=%0d", p, a);
    endtask

    task automatic step_idle();
        @(negedge clk);
        wen = '0; ren = '0; clr_req = 1'b0;
    endtask

    task automatic test_reset();
        int n32, n20, n;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (c_busy !== 1'b1) begin errors++; $display("FAIL reset_busy20: got %b want 1", c_busy); end
        rst = 1'b0;
        n = 0; n32 = -1; n20 = -1;
        while ((busy || c_busy) && n < 100) begin
            @(negedge clk);
            n++;
            if (!busy && n32 < 0) n32 = n;
            if (!c_busy && n20 < 0) n20 = n;
        end
        checks++; if (n32 != 32) begin errors++; $display("FAIL reset_clear_len: got %0d want 32", n32); end
        checks++; if (n20 != 20) begin errors++; $display("FAIL reset_clear_len20: got %0d want 20", n20); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        $display("reset done: clear took %0d / %0d cycles", n32, n20);
    endtask

    task automatic test_same_edge();
        drive_wr(0, 5'd5, 32'hDEADBEEF, 4'b1111);
        drive_rd(1, 5'd5);
        step_idle();
        checks++; if (rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL same_edge: got %h want deadbeef", rdata[1]); end
        raddr[1] = 5'd7;
        step_idle();
        checks++; if (rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_hold: got %h want deadbeef", rdata[1]); end
    endtask

    task automatic test_byte_merge();
        drive_wr(0, 5'd3, 32'h11111111, 4'b0011);
        drive_wr(1, 5'd3, 32'h22222222, 4'b0110);
        step_idle();
        drive_rd(0, 5'd3);
        step_idle();
        checks++; if (rdata[0] !== 32'h00221111) begin errors++; $display("FAIL byte_merge: got %h want 00221111", rdata[0]); end
        drive_wr(1, 5'd3, 32'hAB000000, 4'b1000);
        step_idle();
        checks++; if (rdata[0] !== 32'hAB221111) begin errors++; $display("FAIL byte_top: got %h want ab221111", rdata[0]); end
        drive_wr(0, 5'd12, 32'hAAAAAAAA, 4'b1111);
        drive_wr(1, 5'd12, 32'h55555555, 4'b1111);
        step_idle();
        drive_rd(1, 5'd12);
        step_idle();
        checks++; if (rdata[1] !== 32'hAAAAAAAA) begin errors++; $display("FAIL port_priority: got %h want aaaaaaaa", rdata[1]); end
    endtask

    task automatic test_multi_port();
        drive_wr(0, 5'd10, 32'hCAFEF00D, 4'b1111);
        drive_wr(1, 5'd11, 32'h12345678, 4'b1111);
        step_idle();
        drive_rd(0, 5'd10);
        drive_rd(1, 5'd11);
        step_idle();
        checks++; if (rdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL multi_wr0: got %h want cafef00d", rdata[0]); end
        checks++; if (rdata[1] !== 32'h12345678) begin errors++; $display("FAIL multi_wr1: got %h want 12345678", rdata[1]); end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 20; i += 2) begin
            c_wen = 2'b11; c_wbe = '1;
            c_waddr[0] = 5'(i);     c_wdata[0] = 32'h10000000 + i;
            c_waddr[1] = 5'(i + 1); c_wdata[1] = 32'h10000000 + i + 1;
            $display("wr20 addr=%0d,%0d", i, i + 1);
            @(negedge clk);
        end
        c_waddr[0] = 5'd25; c_wdata[0] = 32'hFFFFFFFF;
        c_waddr[1] = 5'd20; c_wdata[1] = 32'hEEEEEEEE;
        $display("wr20 addr=25,20 (out of range)");
        @(negedge clk);
        c_wen = '0;
        c_ren = 2'b11; c_raddr[0] = 5'd25; c_raddr[1] = 5'd20;
        @(negedge clk);
        checks++; if (c_rdata[0] !== 32'h0) begin errors++; $display("FAIL oor_read25: got %h want 0", c_rdata[0]); end
        checks++; if (c_rdata[1] !== 32'h0) begin errors++; $display("FAIL oor_read20: got %h want 0", c_rdata[1]); end
        for (int i = 0; i < 20; i += 2) begin
            c_raddr[0] = 5'(i); c_raddr[1] = 5'(i + 1);
            @(negedge clk);
            $display("rd20 addr=%0d,%0d", i, i + 1);
            checks++; if (c_rdata[0] !== 32'h10000000 + i) begin errors++; $display("FAIL oor_keep[%0d]: got %h want %h", i, c_rdata[0], 32'h10000000 + i); end
            checks++; if (c_rdata[1] !== 32'h10000001 + i) begin errors++; $display("FAIL oor_keep[%0d]: got %h want %h", i + 1, c_rdata[1], 32'h10000001 + i); end
        end
        c_ren = '0;
    endtask

    task automatic test_clear();
        int n;
        for (int i = 0; i < 32; i += 2) begin
            drive_wr(0, 5'(i), 32'hF0000000 | i, 4'b1111);
            drive_wr(1, 5'(i + 1), 32'hF0000000 | (i + 1), 4'b1111);
            step_idle();
        end
        clr_req = 1'b1;
        drive_wr(0, 5'd31, 32'h5A5A5A5A, 4'b1111);
        step_idle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_start: got %b want 1", busy); end
        clr_req = 1'b1;
        drive_rd(1, 5'd31);
        step_idle();
        checks++; if (rdata[1] !== 32'h5A5A5A5A) begin errors++; $display("FAIL clear_edge_write: got %h want 5a5a5a5a", rdata[1]); end
        drive_wr(0, 5'd2, 32'h77777777, 4'b1111);
        drive_rd(0, 5'd0);
        drive_rd(1, 5'd2);
        step_idle();
        checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL clear_word0: got %h want 0", rdata[0]); end
        checks++; if (rdata[1] !== 32'hF0000002) begin errors++; $display("FAIL clear_drop_wr: got %h want f0000002", rdata[1]); end
        n = 2;
        while (busy && n < 100) begin @(negedge clk); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL clear_len: got %0d want 32", n); end
        for (int i = 0; i < 32; i += 2) begin
            drive_rd(0, 5'(i));
            drive_rd(1, 5'(i + 1));
            step_idle();
            checks++; if (rdata !== '0) begin errors++; $display("FAIL clear_zero[%0d]: got %h want 0", i, rdata); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        drive_wr(0, 5'd20, 32'h13572468, 4'b1111);
        drive_rd(0, 5'd20);
        step_idle();
        checks++; if (rdata[0] !== 32'h13572468) begin errors++; $display("FAIL midclr_pre: got %h want 13572468", rdata[0]); end
        clr_req = 1'b1;
        step_idle();
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        $display("rst asserted at clear count 10");
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclr_rst_busy: got %b want 1", busy); end
        checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL midclr_async_rd: got %h want 0", rdata[0]); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL midclr_len: got %0d want 32", n); end
        drive_rd(0, 5'd20);
        drive_rd(1, 5'd5);
        step_idle();
        checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL midclr_word20: got %h want 0", rdata[0]); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL midclr_word5: got %h want 0", rdata[1]); end
    endtask

    initial begin
        clr_req = 1'b0; ren = '0; wen = '0; raddr = '0; waddr = '0; wdata = '0; wbe = '0;
        c_clr_req = 1'b0; c_ren = '0; c_wen = '0; c_raddr = '0; c_waddr = '0;
        c_wdata = '0; c_wbe = '0;
        test_reset();
        test_same_edge();
        test_byte_merge();
        test_multi_port();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
